// File: rtl/pca_pkg.sv
// Shared constants, group generate/propagate helper and elaboration checks
// for the pipelined carry-lookahead adder.
`ifndef PCA_PKG_MACROS
`define PCA_PKG_MACROS
`define PCA_CHECK_WIDTH(W, S) \
  if (((W) % (S)) != 0) begin : g_bad_width \
    $fatal(1, "WIDTH must be a multiple of SEG_W"); \
  end
`define PCA_CHECK_SEG(S) \
  if (((S) % pca_pkg::GRP_W) != 0) begin : g_bad_seg \
    $fatal(1, "SEG_W must be a multiple of 4"); \
  end
`endif

package pca_pkg;
  localparam int GRP_W = 4;

  // Returns {G, P} of one 4-bit group, both as flat sums of products.
  function automatic logic [1:0] cla_group_gp(input logic [GRP_W-1:0] a,
                                              input logic [GRP_W-1:0] b);
    logic [GRP_W-1:0] g, p;
    g = a & b;
    p = a ^ b;
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
            &p};
  endfunction
endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit two-level carry-lookahead adder: 4-bit groups,
// then a lookahead level across groups. Every carry is a flat sum of products.
module cla_segment
  import pca_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);
  localparam int NGRP = SEG_W / GRP_W;

  logic [SEG_W-1:0] g, p, c;
  logic [NGRP-1:0]  grp_g, grp_p;
  logic [NGRP:0]    grp_c;
  logic             gacc, gterm, bacc, bterm;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar j = 0; j < NGRP; j++) begin : g_grp
    assign {grp_g[j], grp_p[j]} = cla_group_gp(a[j*GRP_W +: GRP_W], b[j*GRP_W +: GRP_W]);
  end

  // grp_c[j] = cin&P[j-1..0] | sum_i G[i]&P[j-1..i+1]; no term feeds another carry
  always_comb begin
    grp_c = '0;
    gacc  = 1'b0;
    gterm = 1'b0;
    for (int j = 0; j <= NGRP; j++) begin
      gacc = cin;
      for (int k = 0; k < j; k++) gacc = gacc & grp_p[k];
      for (int i = 0; i < j; i++) begin
        gterm = grp_g[i];
        for (int k = i + 1; k < j; k++) gterm = gterm & grp_p[k];
        gacc = gacc | gterm;
      end
      grp_c[j] = gacc;
    end
  end

  always_comb begin
    c     = '0;
    bacc  = 1'b0;
    bterm = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      for (int bi = 0; bi < GRP_W; bi++) begin
        bacc = grp_c[j];
        for (int k = 0; k < bi; k++) bacc = bacc & p[j*GRP_W + k];
        for (int i = 0; i < bi; i++) begin
          bterm = g[j*GRP_W + i];
          for (int k = i + 1; k < bi; k++) bterm = bterm & p[j*GRP_W + k];
          bacc = bacc | bterm;
        end
        c[j*GRP_W + bi] = bacc;
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = grp_c[NGRP];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one SEG_W-bit lookahead segment per stage,
// registered inter-segment carries, one global advance enable for flow control.
module pipelined_cla_adder
  import pca_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NSEG = WIDTH / SEG_W;

  `PCA_CHECK_WIDTH(WIDTH, SEG_W)
  `PCA_CHECK_SEG(SEG_W)

  // Index 0 is the input tap; index k+1 is the register bank of stage k.
  logic [NSEG:0]            vld_pipe;
  logic [NSEG:0]            c_pipe;
  logic [NSEG:0][WIDTH-1:0] a_pipe, b_pipe, s_pipe;
  logic                     adv;
  logic                     unused_tail;

  assign adv      = !vld_pipe[NSEG] || out_ready;
  assign in_ready = adv;

  assign vld_pipe[0] = in_valid;
  assign a_pipe[0]   = in_a;
  assign b_pipe[0]   = in_sub ? ~in_b : in_b;
  assign c_pipe[0]   = in_cin ^ in_sub;
  assign s_pipe[0]   = '0;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG_W-1:0] seg_sum;
    logic             seg_cout;
    logic [WIDTH-1:0] s_nxt;
    logic             vld_q, c_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;

    cla_segment #(.SEG_W(SEG_W)) u_seg (
      .a    (a_pipe[k][k*SEG_W +: SEG_W]),
      .b    (b_pipe[k][k*SEG_W +: SEG_W]),
      .cin  (c_pipe[k]),
      .sum  (seg_sum),
      .cout (seg_cout)
    );

    always_comb begin
      s_nxt = s_pipe[k];
      s_nxt[k*SEG_W +: SEG_W] = seg_sum;
    end

    // Operands ride along whole; bits below the current segment go dead and
    // only the MSBs survive to the last stage for the overflow test.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        s_q   <= '0;
      end else if (adv) begin
        vld_q <= vld_pipe[k];
        c_q   <= seg_cout;
        a_q   <= a_pipe[k];
        b_q   <= b_pipe[k];
        s_q   <= s_nxt;
      end
    end

    assign vld_pipe[k+1] = vld_q;
    assign c_pipe[k+1]   = c_q;
    assign a_pipe[k+1]   = a_q;
    assign b_pipe[k+1]   = b_q;
    assign s_pipe[k+1]   = s_q;
  end

  assign out_valid = vld_pipe[NSEG];
  assign out_sum   = s_pipe[NSEG];
  assign out_cout  = c_pipe[NSEG];
  assign out_ovf   = (a_pipe[NSEG][WIDTH-1] == b_pipe[NSEG][WIDTH-1]) &&
                     (s_pipe[NSEG][WIDTH-1] != a_pipe[NSEG][WIDTH-1]);

  assign unused_tail = ^{a_pipe[NSEG][WIDTH-2:0], b_pipe[NSEG][WIDTH-2:0]};
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed table, reset/back-pressure sequences and a parameter sweep for
// pipelined_cla_adder, checked against a signed/unsigned arithmetic model.
module tb_pipelined_cla_adder;
  localparam int W = 32;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a, b;
    logic        sub, cin;
    logic [31:0] sum;
    logic        cout, ovf;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_sub = 1'b0, in_cin = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_cout, out_ovf;
  logic [W-1:0] out_sum;

  pipelined_cla_adder #(.WIDTH(32), .SEG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // Sweep instances share one always-ready stimulus stream.
  logic        sw_valid = 1'b0, sw_sub = 1'b0, sw_cin = 1'b0, sw_ready = 1'b1;
  logic [63:0] sw_a = '0, sw_b = '0;
  logic        s1_rdy, s1_v, s1_co, s1_ov, s2_rdy, s2_v, s2_co, s2_ov, s3_rdy, s3_v, s3_co, s3_ov;
  logic [15:0] s1_sum, s2_sum;
  logic [63:0] s3_sum;

  pipelined_cla_adder #(.WIDTH(16), .SEG_W(4)) u_s16_4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_rdy),
    .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_sub(sw_sub), .in_cin(sw_cin),
    .out_valid(s1_v), .out_ready(sw_ready), .out_sum(s1_sum), .out_cout(s1_co), .out_ovf(s1_ov));
  pipelined_cla_adder #(.WIDTH(16), .SEG_W(16)) u_s16_16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s2_rdy),
    .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_sub(sw_sub), .in_cin(sw_cin),
    .out_valid(s2_v), .out_ready(sw_ready), .out_sum(s2_sum), .out_cout(s2_co), .out_ovf(s2_ov));
  pipelined_cla_adder #(.WIDTH(64), .SEG_W(8)) u_s64_8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s3_rdy),
    .in_a(sw_a), .in_b(sw_b), .in_sub(sw_sub), .in_cin(sw_cin),
    .out_valid(s3_v), .out_ready(sw_ready), .out_sum(s3_sum), .out_cout(s3_co), .out_ovf(s3_ov));

  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic; signed range test for overflow.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input logic cin);
    logic [63:0]        mask;
    logic [66:0]        ua, ub, ur;
    logic signed [66:0] sa, sb, sr, sc, smax, smin;
    res_t               r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a  = a & mask;
    b  = b & mask;
    ua = {3'b0, a};
    ub = {3'b0, b};
    sa = $signed(ua);
    sb = $signed(ub);
    if (a[w-1]) sa = sa - (67'sd1 <<< w);
    if (b[w-1]) sb = sb - (67'sd1 <<< w);
    sc = cin ? 67'sd1 : 67'sd0;
    if (sub) begin
      ur     = ua - ub - {66'b0, cin};
      r.cout = (ua >= ub + {66'b0, cin});
      sr     = sa - sb - sc;
    end else begin
      ur     = ua + ub + {66'b0, cin};
      r.cout = ur[w];
      sr     = sa + sb + sc;
    end
    smax  = (67'sd1 <<< (w - 1)) - 67'sd1;
    smin  = -(67'sd1 <<< (w - 1));
    r.sum = ur[63:0] & mask;
    r.ovf = (sr > smax) || (sr < smin);
    return r;
  endfunction

  // Scoreboard for the main instance during the random phases.
  res_t         q[$];
  res_t         e_mon;
  bit           mon_en = 1'b0, prev_stall = 1'b0;
  int           n_in = 0, n_out = 0, first_out = 0, last_out = 0;
  logic [W-1:0] prev_sum;
  logic         prev_cout, prev_ovf;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_sum", 64'(out_sum), 64'(prev_sum));
        chk("hold_cout", 64'(out_cout), 64'(prev_cout));
        chk("hold_ovf", 64'(out_ovf), 64'(prev_ovf));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("extra_beat", 64'(q.size()), 64'd1);
        else begin
          e_mon = q.pop_front();
          chk("rnd_sum", 64'(out_sum), e_mon.sum);
          chk("rnd_cout", 64'(out_cout), 64'(e_mon.cout));
          chk("rnd_ovf", 64'(out_ovf), 64'(e_mon.ovf));
        end
        if (n_out == 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(W, 64'(in_a), 64'(in_b), in_sub, in_cin));
        n_in++;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_cout  = out_cout;
      prev_ovf   = out_ovf;
    end
  end

  // Sweep history indexed by the edge that samples each beat.
  bit          sw_en = 1'b0;
  bit          hv[256];
  logic [63:0] ha[256], hb[256];
  logic        hs[256], hc[256];

  task automatic sw_check(input string nm, input int n, input int w, input logic rdy,
                          input logic v, input logic [63:0] s, input logic co, input logic ov);
    int   idx;
    res_t e;
    idx = (cyc - n + 1) & 255;
    chk({nm, "_ready"}, 64'(rdy), 64'd1);
    chk({nm, "_valid"}, 64'(v), 64'(hv[idx]));
    if (hv[idx]) begin
      e = model(w, ha[idx], hb[idx], hs[idx], hc[idx]);
      chk({nm, "_sum"}, s, e.sum);
      chk({nm, "_cout"}, 64'(co), 64'(e.cout));
      chk({nm, "_ovf"}, 64'(ov), 64'(e.ovf));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (sw_en) begin
      sw_check("s16_4", 4, 16, s1_rdy, s1_v, 64'(s1_sum), s1_co, s1_ov);
      sw_check("s16_16", 1, 16, s2_rdy, s2_v, 64'(s2_sum), s2_co, s2_ov);
      sw_check("s64_8", 8, 64, s3_rdy, s3_v, s3_sum, s3_co, s3_ov);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  vec_t vecs[11];
  int   lat, idx;
  bit   stale;

  initial begin
    vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[2]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 32'hACF13569, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[6]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[7]  = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b1, 32'h01000101, 1'b0, 1'b0};
    vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[10] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_cout", 64'(out_cout), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table: one beat at a time, latency measured in edges
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b;
      in_sub = vecs[i].sub; in_cin = vecs[i].cin; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("v%0d_sum", i), 64'(out_sum), 64'(vecs[i].sum));
      chk($sformatf("v%0d_cout", i), 64'(out_cout), 64'(vecs[i].cout));
      chk($sformatf("v%0d_ovf", i), 64'(out_ovf), 64'(vecs[i].ovf));
    end

    // Fill the pipe under stall, then reset asynchronously between edges
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 32'(i + 1); in_b = 32'h100; in_sub = 1'b0; in_cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_sum", 64'(out_sum), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    chk("no_stale_beat", 64'(stale), 64'd0);

    // Back-to-back throughput
    q.delete(); n_in = 0; n_out = 0; prev_stall = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      in_sub = 1'($urandom_range(1)); in_cin = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_in", 64'(n_in), 64'd100);
    chk("b2b_out", 64'(n_out), 64'd100);
    chk("b2b_span", 64'(last_out - first_out), 64'd99);
    chk("b2b_drained", 64'(q.size()), 64'd0);

    // Back-pressure with random out_ready
    n_in = 0; n_out = 0;
    for (int i = 0; i < 150; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      in_sub = 1'($urandom_range(1)); in_cin = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_count", 64'(n_out), 64'(n_in));
    chk("bp_drained", 64'(q.size()), 64'd0);
    mon_en = 1'b0;

    // Parameter sweep on the three extra instances
    sw_en = 1'b1;
    for (int i = 0; i < 72; i++) begin
      @(posedge clk); #1;
      sw_valid = (i < 60);
      sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
      sw_sub = 1'($urandom_range(1)); sw_cin = 1'($urandom_range(1));
      if (i % 7 == 3) sw_b = ~sw_a;
      idx = (cyc + 1) & 255;
      hv[idx] = sw_valid; ha[idx] = sw_a; hb[idx] = sw_b; hs[idx] = sw_sub; hc[idx] = sw_cin;
    end
    @(posedge clk); #1;
    sw_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor that generalises the 16-bit lookahead adder to any width. The operand is split into SEG_W-bit segments, each resolved in one pipeline stage with a full 4-bit-group lookahead carry. Inter-segment carries are registered, so throughput is one operation per cycle at a clock rate set by SEG_W rather than WIDTH. The block sits between operand registers and the ALU result bus, using a valid/ready handshake on both sides.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of SEG_W
- SEG_W, 8, bits resolved per pipeline stage; must be a multiple of 4
- NSEG, WIDTH/SEG_W (derived, localparam), number of stages and latency in cycles
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat offered
- in_ready  out  1  block accepts a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = subtract (A - B), 0 = add
- in_cin  in  1  carry-in (add) or borrow-in (sub)
- out_valid  out  1  result beat offered
- out_ready  in  1  consumer accepts a result beat
- out_sum  out  WIDTH  result, modulo 2^WIDTH
- out_cout  out  1  carry out of bit WIDTH-1 (for subtract, 1 = no borrow)
- out_ovf  out  1  two's-complement signed overflow

## Operation
- Effective operands: b_eff = in_sub ? ~in_b : in_b; c_eff = in_cin ^ in_sub.
  - Add: A + B + cin.
  - Subtract: A - B - cin.
- Stage k (0..NSEG-1) computes segment bits [k*SEG_W +: SEG_W].
  - Inputs: the operand slice and the carry registered by stage k-1; stage 0 uses c_eff.
  - Registers: its sum slice, its carry-out, and the still-unprocessed upper operand slices.
  - Already-computed lower sum slices travel forward unchanged.
- Within a stage, lookahead runs in 4-bit groups:
  - Per bit: g = a&b, p = a^b.
  - Per group: G/P over the group's 4 bits; group carries via a second lookahead level across groups.
  - Ripple between bits or groups is not permitted.
- out_ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb). It is computed in the final stage, so the operand MSBs are carried to that stage.
- Each stage has a valid bit; the pipeline holds at most NSEG beats.
- Flow control uses one global advance enable: adv = !out_valid || out_ready.
  - When adv = 1, every stage shifts forward and stage 0 captures the input beat.
  - When adv = 0, every stage holds.
  - in_ready = adv.
- A beat is accepted when in_valid && in_ready. When adv = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- out_* are the final-stage registers. out_sum, out_cout and out_ovf are don't-care while out_valid = 0.

## Timing
- Reset (rst_n low, asynchronous):
  - All valid bits clear, out_valid = 0, in_ready = 1.
  - out_sum = 0, out_cout = 0, out_ovf = 0.
  - Data registers clear to 0.
- Reset asserted mid-operation discards all in-flight beats; no partial result is ever presented.
- Latency: a beat accepted on edge t is presented with out_valid = 1 after edge t+NSEG-1, i.e. NSEG cycles after acceptance. NSEG = 1 is legal and gives a single registered stage.
- Throughput: one beat per cycle while out_ready = 1.
- Back-pressure:
  - While out_valid && !out_ready, all stages, including out_*, hold stable and in_ready = 0.
  - in_ready is combinational from out_valid and out_ready only; there is no path from in_valid.
- Handshake stability: once out_valid = 1, out_* do not change until out_ready = 1.
- Simultaneous output consume and input accept in one cycle is required, with no bubble inserted.
- Wrap-around: the sum is truncated mod 2^WIDTH; the carry goes only to out_cout.

## Structure
- Shared package pca_pkg:
  - GRP_W = 4 constant.
  - Function cla_group_gp(a, b) returning {G, P}.
  - Elaboration-check macros for WIDTH % SEG_W == 0 and SEG_W % 4 == 0; violations are a fatal elaboration error.
- One sub-module, cla_segment: a combinational SEG_W-bit two-level lookahead with inputs a, b, cin and outputs sum, cout.
- The top module instantiates NSEG cla_segment instances in a generate loop and owns all pipeline registers and the valid chain.

## Test plan
All scenarios use WIDTH = 32, SEG_W = 8, latency 4.
- Reset: drive rst_n low mid-stream with 3 beats in flight -> out_valid = 0 and in_ready = 1 immediately (asynchronous); no stale beat appears after release.
- Full-length carry: A = 0xFFFFFFFF, B = 0x00000001, add, cin = 0 -> exactly 4 cycles later out_sum = 0x00000000, out_cout = 1, out_ovf = 0.
- Subtract and overflow:
  - A = 0x80000000, B = 0x00000001, sub -> sum 0x7FFFFFFF, cout = 1, ovf = 1.
  - A = 5, B = 7, sub, cin = 1 -> sum 0xFFFFFFFD, cout = 0.
- Back-to-back throughput: 100 random beats with in_valid and out_ready held at 1 -> 100 results in order on consecutive cycles, each matching the reference model.
- Back-pressure: stream beats while toggling out_ready randomly at 50% -> out_* stable while stalled; no beat lost or duplicated; in_ready low exactly when out_valid && !out_ready.
- Parameter sweep: repeat the random test with (WIDTH, SEG_W) = (16, 4), (16, 16), (64, 8) -> latency equals NSEG and all results match the model.
